pkt_tx: RTL and testbench

PKT_TX -- requirements
Module: pkt_tx

---
 rtl/router_pkg.sv | 26 ++
 rtl/tx_skid_buf.sv | 112 +++++++++++
 rtl/pkt_tx.sv | 121 ++++++++++++
 tb/tb_pkt_tx.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the packet transmit path: default word width,
// header field layout and the fetch-state encoding.
package router_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // Header layout: payload length in the low byte, destination above it.
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 7;
  localparam int DST_LSB = 8;
  localparam int DST_MSB = 15;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  // HDR: the next fetched word is a header.
  // BODY: payload words are still owed by the current packet.
  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } fetch_state_t;

  // Extract the payload length from the low header bits.
  function automatic logic [LEN_W-1:0] hdr_len(input logic [DST_MSB:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/tx_skid_buf.sv
// Two-entry registered output buffer for the link side. The head entry
// drives the link directly from registers; the skid entry absorbs one word
// arriving while the head is stalled. Each entry carries sop/eop tags.
module tx_skid_buf
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop,
  input  logic              tx_ready,
  output logic [1:0]        occupancy
);

  logic              head_valid_reg, head_valid_next;
  logic [DATA_W-1:0] head_data_reg,  head_data_next;
  logic              head_sop_reg,   head_sop_next;
  logic              head_eop_reg,   head_eop_next;

  logic              skid_valid_reg, skid_valid_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
  logic              skid_sop_reg,   skid_sop_next;
  logic              skid_eop_reg,   skid_eop_next;

  logic              head_free;

  // The head can take a new word when empty or when its word leaves now.
  assign head_free = !head_valid_reg || tx_ready;

  // Advance the two entries: refill head from skid first, then from input.
  always_comb begin
    head_valid_next = head_valid_reg;
    head_data_next  = head_data_reg;
    head_sop_next   = head_sop_reg;
    head_eop_next   = head_eop_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    skid_sop_next   = skid_sop_reg;
    skid_eop_next   = skid_eop_reg;

    if (head_free) begin
      if (skid_valid_reg) begin
        // Older word sits in skid; it moves to head, input refills skid.
        head_valid_next = 1'b1;
        head_data_next  = skid_data_reg;
        head_sop_next   = skid_sop_reg;
        head_eop_next   = skid_eop_reg;
        skid_valid_next = in_valid;
        if (in_valid) begin
          skid_data_next = in_data;
          skid_sop_next  = in_sop;
          skid_eop_next  = in_eop;
        end
      end else begin
        head_valid_next = in_valid;
        if (in_valid) begin
          head_data_next = in_data;
          head_sop_next  = in_sop;
          head_eop_next  = in_eop;
        end else begin
          // Drop stale tags once the head empties.
          head_sop_next = 1'b0;
          head_eop_next = 1'b0;
        end
      end
    end else if (in_valid) begin
      // Head is stalled; the upstream guarantees skid is free here.
      skid_valid_next = 1'b1;
      skid_data_next  = in_data;
      skid_sop_next   = in_sop;
      skid_eop_next   = in_eop;
    end
  end

  // Entry registers; reset empties both entries and clears the link outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
      head_sop_reg   <= 1'b0;
      head_eop_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_sop_reg   <= 1'b0;
      skid_eop_reg   <= 1'b0;
    end else begin
      head_valid_reg <= head_valid_next;
      head_data_reg  <= head_data_next;
      head_sop_reg   <= head_sop_next;
      head_eop_reg   <= head_eop_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      skid_sop_reg   <= skid_sop_next;
      skid_eop_reg   <= skid_eop_next;
    end
  end

  assign tx_valid  = head_valid_reg;
  assign tx_data   = head_data_reg;
  assign tx_sop    = head_sop_reg;
  assign tx_eop    = head_eop_reg;
  assign occupancy = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: rtl/pkt_tx.sv
// Packet transmitter: pops words from a FIFO, tags each as it arrives
// (sop on headers, eop on the last word of a packet), buffers them in a
// two-entry skid buffer and counts packets whose eop the link accepted.
module pkt_tx
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  fetch_state_t     state_reg, state_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic             inflight_reg;
  logic [CNT_W-1:0] pkt_count_reg;

  logic [LEN_W-1:0] arrived_len;
  logic             cap_sop;
  logic             cap_eop;
  logic [1:0]       occupancy;
  logic             word_accepted;
  logic [2:0]       committed;
  logic             room;
  logic             may_fetch;

  // Length field of the word arriving this cycle (meaningful for headers).
  assign arrived_len = hdr_len(fifo_dout[DST_MSB:0]);

  // Classify the arriving word and advance the fetch FSM; the resulting
  // state is also the role of the next word to be popped.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    cap_sop        = 1'b0;
    cap_eop        = 1'b0;
    if (inflight_reg) begin
      case (state_reg)
        ST_HDR: begin
          cap_sop = 1'b1;
          if (arrived_len == '0) begin
            cap_eop = 1'b1;
          end else begin
            state_next     = ST_BODY;
            remaining_next = arrived_len;
          end
        end
        ST_BODY: begin
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) begin
            cap_eop    = 1'b1;
            state_next = ST_HDR;
          end
        end
        default: begin
          state_next = ST_HDR;
        end
      endcase
    end
  end

  // Pop control: the buffer plus the word in flight, minus any word leaving
  // this cycle, must leave room for one more. Headers also need enable;
  // payload words are fetched regardless so a started packet completes.
  assign word_accepted = tx_valid && tx_ready;
  assign committed     = {1'b0, occupancy} + {2'b00, inflight_reg}
                         - {2'b00, word_accepted};
  assign room          = committed < 3'd2;
  assign may_fetch     = (state_next == ST_BODY) || enable;
  assign fifo_pop      = !reset && !fifo_empty && room && may_fetch;

  // FSM, in-flight flag and packet counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_HDR;
      remaining_reg <= '0;
      inflight_reg  <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      inflight_reg  <= fifo_pop;
      if (word_accepted && tx_eop) begin
        pkt_count_reg <= pkt_count_reg + CNT_W'(1);
      end
    end
  end

  tx_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (inflight_reg),
    .in_data   (fifo_dout),
    .in_sop    (cap_sop),
    .in_eop    (cap_eop),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_ready  (tx_ready),
    .occupancy (occupancy)
  );

  assign pkt_count = pkt_count_reg;
  assign busy      = (state_reg == ST_BODY) || (occupancy != 2'd0) || inflight_reg;

endmodule

// File: tb/tb_pkt_tx.sv
// Directed bench for pkt_tx: a queue-backed FIFO model feeds the design,
// a link monitor collects accepted words, and every result goes through
// check_val against hand-derived expectations.
`timescale 1ns/1ps
module tb_pkt_tx;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_pop;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic              tx_sop;
  logic              tx_eop;
  logic              busy;
  logic [CNT_W-1:0]  pkt_count;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W+1:0] rx_q[$];   // {sop, eop, data}
  logic [DATA_W+1:0] exp_q[$];

  int pops = 0;
  int accs = 0;
  int max_occ = 0;
  int pop_empty_err = 0;
  int cyc = 0;
  int first_acc_cyc = -1;
  int last_acc_cyc = -1;
  int idle_cyc = 0;
  bit stall_prev = 1'b0;
  logic [DATA_W+1:0] stall_word = '0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int base;

  always #5 clock = ~clock;

  pkt_tx #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_sop     (tx_sop),
    .tx_eop     (tx_eop),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: read data appears the cycle after an accepted pop.
  always @(posedge clock) begin
    if (fifo_pop && fifo_q.size() != 0) begin
      fifo_dout <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Link monitor, sampled mid-cycle: collects accepted words, checks hold
  // during stalls and tracks buffered + in-flight occupancy.
  always @(negedge clock) begin : mon
    int occ;
    cyc++;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_val("hold", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, stall_word});
      end
      occ = pops - accs;
      if (occ > max_occ) max_occ = occ;
      if (fifo_pop) begin
        pops++;
        if (fifo_empty) pop_empty_err++;
      end
      if (tx_valid && tx_ready) begin
        accs++;
        rx_q.push_back({tx_sop, tx_eop, tx_data});
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end else if (!tx_valid && busy && rx_q.size() > 0) begin
        idle_cyc++;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_word = {tx_sop, tx_eop, tx_data};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_word(input logic sop, input logic eop, input logic [DATA_W-1:0] d);
    exp_q.push_back({sop, eop, d});
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (rx_q.size() < n) check_val({tag, "_timeout"}, rx_q.size(), n);
  endtask

  task automatic compare_rx(input string tag);
    check_val({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_val($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a preloaded FIFO: nothing may move while reset is high.
    fifo_q.push_back(32'h0000_0003);
    fifo_q.push_back(32'h0000_000A);
    fifo_q.push_back(32'h0000_000B);
    fifo_q.push_back(32'h0000_000C);
    enable   = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val($sformatf("rst_pop_c%0d", i), fifo_pop, 0);
      check_val($sformatf("rst_valid_c%0d", i), tx_valid, 0);
      check_val($sformatf("rst_cnt_c%0d", i), pkt_count, 0);
    end
    check_val("rst_busy", busy, 0);
    reset = 1'b0;
    wait_rx("rst_pkt", 4, 50);
    repeat (4) tick();
    expect_word(1'b1, 1'b0, 32'h0000_0003);
    expect_word(1'b0, 1'b0, 32'h0000_000A);
    expect_word(1'b0, 1'b0, 32'h0000_000B);
    expect_word(1'b0, 1'b1, 32'h0000_000C);
    compare_rx("rst_pkt");
    exp_cnt = 16'd1;
    check_val("rst_pkt_count", pkt_count, exp_cnt);

    // Back-to-back: L=3 then L=0, continuous ready, no gaps after first word.
    first_acc_cyc = -1;
    fifo_q.push_back(32'h0000_5503);
    fifo_q.push_back(32'h0000_000A);
    fifo_q.push_back(32'h0000_000B);
    fifo_q.push_back(32'h0000_000C);
    fifo_q.push_back(32'h0000_7700);
    wait_rx("b2b", 5, 50);
    repeat (4) tick();
    check_val("b2b_span", last_acc_cyc - first_acc_cyc, 4);
    expect_word(1'b1, 1'b0, 32'h0000_5503);
    expect_word(1'b0, 1'b0, 32'h0000_000A);
    expect_word(1'b0, 1'b0, 32'h0000_000B);
    expect_word(1'b0, 1'b1, 32'h0000_000C);
    expect_word(1'b1, 1'b1, 32'h0000_7700);
    compare_rx("b2b");
    exp_cnt = exp_cnt + 16'd2;
    check_val("b2b_pkt_count", pkt_count, exp_cnt);

    // Backpressure: random ready, outputs held while stalled.
    max_occ = 0;
    fifo_q.push_back(32'h0000_AB02);
    fifo_q.push_back(32'h1111_1111);
    fifo_q.push_back(32'h2222_2222);
    for (int k = 0; k < 200 && rx_q.size() < 3; k++) begin
      tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
    if (rx_q.size() < 3) check_val("bp_timeout", rx_q.size(), 3);
    repeat (4) tick();
    expect_word(1'b1, 1'b0, 32'h0000_AB02);
    expect_word(1'b0, 1'b0, 32'h1111_1111);
    expect_word(1'b0, 1'b1, 32'h2222_2222);
    compare_rx("bp");
    check_val("bp_occ_le2", max_occ <= 2, 1);
    exp_cnt = exp_cnt + 16'd1;
    check_val("bp_pkt_count", pkt_count, exp_cnt);

    // Starvation: payload trickles in every 5 cycles.
    idle_cyc = 0;
    fifo_q.push_back(32'h0000_0004);
    for (int i = 1; i <= 4; i++) begin
      repeat (5) tick();
      if (i == 1) begin
        check_val("starve_busy", busy, 1);
        check_val("starve_valid_low", tx_valid, 0);
      end
      fifo_q.push_back(32'h0000_0040 + i);
    end
    wait_rx("starve", 5, 100);
    repeat (4) tick();
    check_val("starve_gaps", idle_cyc > 0, 1);
    expect_word(1'b1, 1'b0, 32'h0000_0004);
    expect_word(1'b0, 1'b0, 32'h0000_0041);
    expect_word(1'b0, 1'b0, 32'h0000_0042);
    expect_word(1'b0, 1'b0, 32'h0000_0043);
    expect_word(1'b0, 1'b1, 32'h0000_0044);
    compare_rx("starve");
    exp_cnt = exp_cnt + 16'd1;
    check_val("starve_pkt_count", pkt_count, exp_cnt);

    // Enable dropped right after the header is popped.
    base = pops;
    fifo_q.push_back(32'h0000_0002);
    fifo_q.push_back(32'h0000_0051);
    fifo_q.push_back(32'h0000_0052);
    fifo_q.push_back(32'h0000_9900);
    for (int k = 0; k < 20 && pops == base; k++) tick();
    enable = 1'b0;
    wait_rx("en_pkt", 3, 50);
    repeat (10) tick();
    check_val("en_pops_held", pops - base, 3);
    check_val("en_fifo_left", fifo_q.size(), 1);
    check_val("en_idle_busy", busy, 0);
    expect_word(1'b1, 1'b0, 32'h0000_0002);
    expect_word(1'b0, 1'b0, 32'h0000_0051);
    expect_word(1'b0, 1'b1, 32'h0000_0052);
    compare_rx("en_pkt");
    exp_cnt = exp_cnt + 16'd1;
    check_val("en_pkt_count", pkt_count, exp_cnt);
    enable = 1'b1;
    wait_rx("en_next", 1, 20);
    repeat (4) tick();
    expect_word(1'b1, 1'b1, 32'h0000_9900);
    compare_rx("en_next");
    exp_cnt = exp_cnt + 16'd1;
    check_val("en_next_count", pkt_count, exp_cnt);

    // Reset in the middle of an L=5 packet.
    fifo_q.push_back(32'h0000_0005);
    fifo_q.push_back(32'h0000_0061);
    fifo_q.push_back(32'h0000_0062);
    fifo_q.push_back(32'h0000_0063);
    wait_rx("mid", 3, 50);
    expect_word(1'b1, 1'b0, 32'h0000_0005);
    expect_word(1'b0, 1'b0, 32'h0000_0061);
    expect_word(1'b0, 1'b0, 32'h0000_0062);
    compare_rx("mid");
    tx_ready = 1'b0;
    reset    = 1'b1;
    fifo_q.delete();
    tick();
    check_val("mid_rst_pop", fifo_pop, 0);
    tick();
    check_val("mid_rst_pop2", fifo_pop, 0);
    check_val("mid_rst_out", {tx_valid, tx_sop, tx_eop, tx_data}, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_cnt", pkt_count, 0);
    pops = 0;
    accs = 0;
    reset    = 1'b0;
    tx_ready = 1'b1;
    fifo_q.push_back(32'h0000_0001);
    fifo_q.push_back(32'h0000_0071);
    wait_rx("post_rst", 2, 50);
    repeat (4) tick();
    expect_word(1'b1, 1'b0, 32'h0000_0001);
    expect_word(1'b0, 1'b1, 32'h0000_0071);
    compare_rx("post_rst");
    exp_cnt = 16'd1;
    check_val("post_rst_count", pkt_count, exp_cnt);

    // Counter wrap: 65534 more single-word packets reach 0xFFFF, one more wraps.
    for (int i = 0; i < 65534; i++) begin
      fifo_q.push_back({16'h0000, 8'(i), 8'h00});
    end
    wait_rx("wrap", 65534, 70000);
    repeat (4) tick();
    check_val("wrap_rx_count", rx_q.size(), 65534);
    if (rx_q.size() > 0) check_val("wrap_last_word", rx_q[rx_q.size()-1], {2'b11, 16'h0000, 8'hFD, 8'h00});
    rx_q.delete();
    check_val("wrap_ffff", pkt_count, 16'hFFFF);
    fifo_q.push_back(32'h0000_3300);
    wait_rx("wrap_last", 1, 20);
    repeat (4) tick();
    expect_word(1'b1, 1'b1, 32'h0000_3300);
    compare_rx("wrap_last");
    check_val("wrap_zero", pkt_count, 16'h0000);

    check_val("pop_when_empty", pop_empty_err, 0);
    check_val("occ_le2_overall", max_occ <= 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
